// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - replays the first round_len generator colours on the LEDs
// Walks the generator with start_over/next and blanks the LEDs between colours.

module sequence_player #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_LEN    = 32,
    parameter int LEN_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             play,
    input  logic [LEN_W-1:0] round_len,
    input  logic [3:0]       seq,
    output logic             start_over,
    output logic             next,
    output logic [3:0]       leds,
    output logic             busy,
    output logic             done
);

    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REWIND,
        SETTLE,
        SHOW,
        GAP,
        ADVANCE,
        FINISH
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] step;
    logic [LEN_W-1:0] len_sat;

    assign len_sat = (round_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : round_len;

    // Outputs are assigned together with the state they belong to, so each
    // output is valid in exactly the cycle its state is resident.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            len        <= '0;
            step       <= '0;
            start_over <= 1'b0;
            next       <= 1'b0;
            leds       <= 4'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            start_over <= 1'b0;
            next       <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (play) begin
                        if (round_len != '0) begin
                            state      <= REWIND;
                            len        <= len_sat;
                            step       <= '0;
                            start_over <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                REWIND: begin
                    state <= SETTLE;
                    leds  <= 4'b0;
                end
                SETTLE: begin
                    // Generator output is stable one cycle after start_over/next.
                    state <= SHOW;
                    leds  <= seq;
                    timer <= TW'(ON_CYCLES - 1);
                end
                SHOW: begin
                    if (timer == '0) begin
                        state <= GAP;
                        leds  <= 4'b0;
                        timer <= TW'(OFF_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        if (step == len - LEN_W'(1)) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ADVANCE;
                            next  <= 1'b1;
                            step  <= step + LEN_W'(1);
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ADVANCE: begin
                    state <= SETTLE;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    leds  <= 4'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - table, directed and random checks of sequence_player
module tb_sequence_player;

    localparam int ON      = 4;
    localparam int OFF     = 2;
    localparam int MAXL    = 32;
    localparam int LW      = 6;
    localparam int P       = ON + OFF + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          play = 1'b0;
    logic [LW-1:0] round_len = '0;
    logic [3:0]    seq;
    logic          start_over, next, busy, done;
    logic [3:0]    leds;

    int vectors = 0;
    int errors  = 0;

    sequence_player #(
        .ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_LEN(MAXL), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .round_len(round_len),
        .seq(seq), .start_over(start_over), .next(next), .leds(leds),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Generator model: rewinds to colour 0 on start_over, steps on next.
    logic [7:0] gen_idx = 8'd3;
    always @(posedge clk) begin
        if (start_over)  gen_idx <= 8'd0;
        else if (next)   gen_idx <= gen_idx + 8'd1;
    end
    assign seq = 4'b0001 << gen_idx[1:0];

    typedef struct {
        int rl;
        int done_cyc;
        int nexts;
        int shows;
    } vec_t;

    vec_t table_v[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {start_over, next, busy, done, leds} for cycle c after play sampled at cycle 0
    function automatic logic [7:0] exp_out(input int c, input int n);
        logic so, nx, bz, dn;
        logic [3:0] ld;
        int last, k, r;
        so = 0; nx = 0; bz = 0; dn = 0; ld = 4'b0;
        if (n == 0) begin
            dn = (c == 1);
        end else begin
            last = n * P;
            so = (c == 1);
            bz = (c >= 1) && (c <= last);
            dn = (c == last + 1);
            if (c >= 3 && c <= last) begin
                k = (c - 3) / P;
                r = (c - 3) % P;
                if (r < ON) ld = 4'b0001 << (k % 4);
                if (r == ON + OFF && k < n - 1) nx = 1;
            end
        end
        return {so, nx, bz, dn, ld};
    endfunction

    function automatic logic [7:0] act_out();
        return {start_over, next, busy, done, leds};
    endfunction

    task automatic run_play(input int rl, input bit noise, input string tag,
                            output int done_at, output int dones,
                            output int nexts, output int shows);
        int n, dc;
        logic [3:0] prev;
        n  = (rl > MAXL) ? MAXL : rl;
        dc = (n == 0) ? 1 : n * P + 1;
        @(negedge clk);
        round_len = LW'(rl);
        play = 1'b1;
        done_at = -1; dones = 0; nexts = 0; shows = 0; prev = 4'b0;
        for (int c = 1; c <= dc + 3; c++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, c), 32'(act_out()), 32'(exp_out(c, n)));
            if (done) begin done_at = c; dones++; end
            if (next) nexts++;
            if (leds != 4'b0 && prev == 4'b0) shows++;
            prev = leds;
            if (noise && c < dc) begin
                play = 1'($urandom_range(0, 1));
                round_len = LW'($urandom_range(0, 63));
            end else begin
                play = 1'b0;
            end
        end
    endtask

    initial begin
        int d_at, d_n, nx, sh, rl;

        table_v[0] = '{1, 9, 0, 1};
        table_v[1] = '{3, 25, 2, 3};
        table_v[2] = '{0, 1, 0, 0};
        table_v[3] = '{40, 257, 31, 32};
        table_v[4] = '{2, 17, 1, 2};
        table_v[5] = '{32, 257, 31, 32};
        table_v[6] = '{33, 257, 31, 32};

        // Reset held with play asserted: everything stays quiet.
        reset_n = 1'b0; play = 1'b1; round_len = LW'(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset cyc%0d", i), 32'(act_out()), 32'h0);
        end
        play = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'(act_out()), 32'h0);

        foreach (table_v[i]) begin
            run_play(table_v[i].rl, 1'b0, $sformatf("tbl%0d", i), d_at, d_n, nx, sh);
            check($sformatf("tbl%0d done_at", i), 32'(d_at), 32'(table_v[i].done_cyc));
            check($sformatf("tbl%0d dones", i), 32'(d_n), 32'd1);
            check($sformatf("tbl%0d nexts", i), 32'(nx), 32'(table_v[i].nexts));
            check($sformatf("tbl%0d shows", i), 32'(sh), 32'(table_v[i].shows));
        end

        // Play/round_len noise during playback must not disturb a 3-step round.
        run_play(3, 1'b1, "noise3", d_at, d_n, nx, sh);
        check("noise3 done_at", 32'(d_at), 32'd25);
        check("noise3 dones", 32'(d_n), 32'd1);

        // Mid-playback play at cycle 12, reset at cycle 13, then a clean replay.
        @(negedge clk);
        round_len = LW'(3);
        play = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            check($sformatf("midrst cyc%0d", c), 32'(act_out()), 32'(exp_out(c, 3)));
            play = 1'b0;
            if (c == 12) begin play = 1'b1; round_len = LW'(5); end
            if (c == 13) reset_n = 1'b0;
        end
        @(negedge clk);
        check("midrst cyc14 zero", 32'(act_out()), 32'h0);
        reset_n = 1'b1;
        for (int c = 15; c <= 40; c++) begin
            @(negedge clk);
            check($sformatf("midrst quiet cyc%0d", c), 32'(act_out()), 32'h0);
        end
        run_play(2, 1'b0, "after_rst", d_at, d_n, nx, sh);
        check("after_rst done_at", 32'(d_at), 32'd17);
        check("after_rst shows", 32'(sh), 32'd2);

        for (int t = 0; t < 20; t++) begin
            rl = $urandom_range(0, 40);
            run_play(rl, 1'b1, $sformatf("rnd%0d_len%0d", t, rl), d_at, d_n, nx, sh);
            check($sformatf("rnd%0d dones", t), 32'(d_n), 32'd1);
            check($sformatf("rnd%0d nexts", t), 32'(nx),
                  32'((rl == 0) ? 0 : ((rl > MAXL) ? MAXL : rl) - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
